// File: rtl/intan_frame_sched.sv
// rtl/intan_frame_sched.sv - intan check/configure/read sequencer that frames drained FIFO bytes
// Frame: HDR, frame counter, lane-1 bytes, lane-0 bytes, XOR checksum (m_last).
module intan_frame_sched #(
    parameter logic [7:0]  HDR       = 8'hA5,
    parameter int          MAX_BYTES = 64,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        fs_check,
    input  logic        fd_check,
    output logic        fs_conf,
    input  logic        fd_conf,
    output logic        fs_read,
    input  logic        fd_read,
    input  logic [1:0]  fifo_full,
    input  logic [1:0]  fifo_empty,
    output logic [1:0]  fifo_rxen,
    input  logic [15:0] fifo_rxd,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [7:0]  frame_cnt,
    output logic        err,
    output logic [7:0]  state
);

    localparam logic [7:0] S_IDLE  = 8'h01;
    localparam logic [7:0] S_CHECK = 8'h02;
    localparam logic [7:0] S_CONF  = 8'h04;
    localparam logic [7:0] S_PREP  = 8'h08;
    localparam logic [7:0] S_FITX  = 8'h10;
    localparam logic [7:0] S_HEAD  = 8'h20;
    localparam logic [7:0] S_DRAIN = 8'h40;
    localparam logic [7:0] S_TAIL  = 8'h80;
    localparam logic [7:0] MAXB    = 8'(MAX_BYTES);

    logic [7:0]  r_state;
    logic [7:0]  r_data;
    logic [7:0]  r_csum;
    logic [7:0]  r_frame;
    logic [7:0]  r_cnt;
    logic [15:0] r_tmo;
    logic        r_valid;
    logic        r_last;
    logic        r_err;
    logic        r_lane;
    logic        r_inflt;
    logic        r_hsel;

    logic        w_free;
    logic        w_lane_empty;
    logic        w_cap;
    logic        w_lane_done;
    logic        w_issue;
    logic        w_tmo_hit;
    logic [7:0]  w_rxbyte;

    // The output register can take a new byte if it is empty or being accepted now.
    assign w_free       = !r_valid || m_ready;
    assign w_lane_empty = r_lane ? fifo_empty[1] : fifo_empty[0];
    assign w_cap        = (r_cnt == MAXB);
    assign w_lane_done  = !r_inflt && (w_lane_empty || w_cap);
    assign w_issue      = (r_state == S_DRAIN) && !r_inflt && !w_lane_empty && !w_cap && w_free;
    assign w_tmo_hit    = (r_tmo == TIMEOUT - 16'd1);
    assign w_rxbyte     = r_lane ? fifo_rxd[15:8] : fifo_rxd[7:0];

    always_comb begin
        fifo_rxen = 2'b00;
        if (w_issue) fifo_rxen = r_lane ? 2'b10 : 2'b01;
    end

    assign fs_check  = (r_state == S_CHECK);
    assign fs_conf   = (r_state == S_CONF);
    assign fs_read   = (r_state == S_FITX);
    assign m_data    = r_data;
    assign m_valid   = r_valid;
    assign m_last    = r_last;
    assign frame_cnt = r_frame;
    assign err       = r_err;
    assign state     = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_data  <= 8'd0;
            r_csum  <= 8'd0;
            r_frame <= 8'd0;
            r_cnt   <= 8'd0;
            r_tmo   <= 16'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_lane  <= 1'b0;
            r_inflt <= 1'b0;
            r_hsel  <= 1'b0;
        end else begin
            r_tmo <= r_tmo + 16'd1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_CHECK;
                    r_tmo   <= 16'd0;
                end
                S_CHECK: if (fd_check) begin
                    r_state <= S_CONF;
                    r_tmo   <= 16'd0;
                end else if (w_tmo_hit) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_CONF: if (fd_conf) begin
                    r_state <= S_PREP;
                end else if (w_tmo_hit) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_PREP: if (!start) begin
                    r_state <= S_IDLE;
                end else if (fifo_full == 2'b00) begin
                    r_state <= S_FITX;
                    r_tmo   <= 16'd0;
                end
                S_FITX: if (fd_read) begin
                    r_state <= S_HEAD;
                    r_data  <= HDR;
                    r_csum  <= HDR;
                    r_valid <= 1'b1;
                    r_hsel  <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_HEAD: if (r_valid && m_ready) begin
                    if (!r_hsel) begin
                        r_data <= r_frame;
                        r_csum <= r_csum ^ r_frame;
                        r_hsel <= 1'b1;
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= S_DRAIN;
                        r_lane  <= 1'b1;
                        r_cnt   <= 8'd0;
                    end
                end
                S_DRAIN: begin
                    if (r_valid && m_ready) r_valid <= 1'b0;
                    // Read data is valid the cycle after rxen; the register is free by construction.
                    if (r_inflt) begin
                        r_data  <= w_rxbyte;
                        r_csum  <= r_csum ^ w_rxbyte;
                        r_valid <= 1'b1;
                        r_inflt <= 1'b0;
                    end else if (w_issue) begin
                        r_inflt <= 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                    end else if (w_lane_done) begin
                        if (r_lane) begin
                            r_lane <= 1'b0;
                            r_cnt  <= 8'd0;
                        end else begin
                            r_state <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (r_last) begin
                        if (m_ready) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_frame <= r_frame + 8'd1;
                            r_state <= S_PREP;
                        end
                    end else if (w_free) begin
                        r_data  <= r_csum;
                        r_valid <= 1'b1;
                        r_last  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intan_frame_sched.sv
// tb/tb_intan_frame_sched.sv - directed bench for intan_frame_sched with FIFO and handshake models
module tb_intan_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fd_check = 1'b0;
    logic        fd_conf = 1'b0;
    logic        fd_read = 1'b0;
    logic [1:0]  fifo_full = 2'b00;
    logic [1:0]  fifo_empty = 2'b11;
    logic [15:0] fifo_rxd = 16'd0;
    logic        m_ready = 1'b1;
    logic        fs_check, fs_conf, fs_read, m_valid, m_last, err;
    logic [1:0]  fifo_rxen;
    logic [7:0]  m_data, frame_cnt, state;

    always #5 clk = ~clk;

    intan_frame_sched #(.HDR(8'hA5), .MAX_BYTES(4), .TIMEOUT(16'd20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .fs_check(fs_check), .fd_check(fd_check),
        .fs_conf(fs_conf), .fd_conf(fd_conf),
        .fs_read(fs_read), .fd_read(fd_read),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_rxen(fifo_rxen), .fifo_rxd(fifo_rxd),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_cnt(frame_cnt), .err(err), .state(state)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Front-end responder: answers each request a fixed number of cycles after it rises.
    int c_ck = 0, c_cf = 0, c_rd = 0;
    bit conf_en = 1'b1;
    always @(posedge clk) begin
        fd_check <= fs_check && (c_ck == 3);
        fd_conf  <= conf_en && fs_conf && (c_cf == 3);
        fd_read  <= fs_read && (c_rd == 2);
        c_ck <= fs_check ? c_ck + 1 : 0;
        c_cf <= fs_conf ? c_cf + 1 : 0;
        c_rd <= fs_read ? c_rd + 1 : 0;
    end

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    always @(posedge clk) begin
        logic [7:0] b1, b0;
        b1 = fifo_rxd[15:8];
        b0 = fifo_rxd[7:0];
        if (fifo_rxen[1] && q1.size() > 0) b1 = q1.pop_front();
        if (fifo_rxen[0] && q0.size() > 0) b0 = q0.pop_front();
        fifo_rxd   <= {b1, b0};
        fifo_empty <= {q1.size() == 0, q0.size() == 0};
    end

    bit rdy_tog = 1'b0;
    int rdy_ph = 0;
    always @(posedge clk) begin
        #2;
        if (rdy_tog) begin
            m_ready = (rdy_ph == 0) || (rdy_ph == 3);
            rdy_ph  = (rdy_ph + 1) % 4;
        end
    end

    logic [7:0] cap[$];
    bit         caplast[$];
    logic [7:0] st_seq[$];
    int n_last = 0;
    int v_stall = 0, v_rxen = 0, v_rxocc = 0, v_fs = 0;
    bit p_stall = 1'b0;
    logic [7:0] p_data = 8'd0;
    always @(negedge clk) begin
        if (!rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall && (!m_valid || m_data !== p_data)) v_stall++;
            if (fifo_rxen != 2'b00 && state != 8'h40) v_rxen++;
            if (fifo_rxen != 2'b00 && m_valid && !m_ready) v_rxocc++;
            if (fs_check != (state == 8'h02) || fs_conf != (state == 8'h04) || fs_read != (state == 8'h10)) v_fs++;
            if (st_seq.size() == 0 || st_seq[$] != state) st_seq.push_back(state);
            if (m_valid && m_ready) begin
                cap.push_back(m_data);
                caplast.push_back(m_last);
                if (m_last) n_last++;
            end
            p_stall = m_valid && !m_ready;
            p_data  = m_data;
        end
    end

    task automatic wait_state(input string tag, input logic [7:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin @(negedge clk); n++; end
        if (state !== s) check(tag, state, s);
    endtask

    task automatic wait_lasts(input string tag, input int target, input int budget);
        int n = 0;
        while (n_last < target && n < budget) begin @(negedge clk); n++; end
        if (n_last < target) check(tag, n_last, target);
    endtask

    logic [7:0] exp_pay[$];
    task automatic check_frame(input string tag, input int base, input logic [7:0] fc);
        logic [7:0]  e[$];
        logic [7:0]  x;
        logic [31:0] got_mask, got;
        e.push_back(8'hA5);
        e.push_back(fc);
        foreach (exp_pay[i]) e.push_back(exp_pay[i]);
        x = 8'd0;
        foreach (e[i]) x ^= e[i];
        e.push_back(x);
        check({tag, "_len"}, cap.size() - base, e.size());
        got_mask = 32'd0;
        for (int i = 0; i < e.size(); i++) begin
            got = (base + i < cap.size()) ? {24'd0, cap[base + i]} : 32'hDEAD;
            check($sformatf("%s_b%0d", tag, i), got, {24'd0, e[i]});
            if (base + i < caplast.size() && caplast[base + i]) got_mask[i] = 1'b1;
        end
        check({tag, "_last"}, got_mask, 32'd1 << (e.size() - 1));
    endtask

    task automatic one_frame(input string tag);
        start = 1'b1;
        wait_state({tag, "_fitx"}, 8'h10, 100);
        start = 1'b0;
        wait_lasts({tag, "_done"}, n_last + 1, 400);
        wait_state({tag, "_idle"}, 8'h01, 50);
    endtask

    logic [7:0] seq_exp [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

    initial begin
        int base, n, l0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 8'h01);
        check("rst_outs", {fs_check, fs_conf, fs_read, fifo_rxen, m_valid, m_last, err}, 32'd0);
        check("rst_mdata", m_data, 8'h00);
        check("rst_fcnt", frame_cnt, 8'h00);
        rst = 1'b1;

        q1.push_back(8'h11); q1.push_back(8'h22); q0.push_back(8'h33);
        @(negedge clk);
        one_frame("norm");
        exp_pay.delete(); exp_pay.push_back(8'h11); exp_pay.push_back(8'h22); exp_pay.push_back(8'h33);
        check_frame("norm", 0, 8'h00);
        check("norm_csum", cap.size() > 5 ? cap[5] : 8'h00, 8'hA5);
        check("norm_fcnt", frame_cnt, 8'h01);
        for (int i = 0; i < 6; i++)
            check($sformatf("seq%0d", i), i < st_seq.size() ? st_seq[i] : 8'h00, seq_exp[i]);

        base = cap.size();
        q1.push_back(8'h11); q1.push_back(8'h22); q0.push_back(8'h33);
        rdy_ph = 0; rdy_tog = 1'b1;
        @(negedge clk);
        one_frame("bp");
        rdy_tog = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        check_frame("bp", base, 8'h01);
        check("bp_csum", cap.size() > base + 5 ? cap[base + 5] : 8'h00, 8'hA4);
        check("bp_stable", v_stall, 0);
        check("bp_rxen_occ", v_rxocc, 0);

        base = cap.size();
        for (int i = 1; i <= 6; i++) q1.push_back(8'(i));
        q0.push_back(8'h77);
        @(negedge clk);
        one_frame("max1");
        exp_pay.delete();
        exp_pay.push_back(8'h01); exp_pay.push_back(8'h02); exp_pay.push_back(8'h03);
        exp_pay.push_back(8'h04); exp_pay.push_back(8'h77);
        check_frame("max1", base, 8'h02);
        base = cap.size();
        one_frame("max2");
        exp_pay.delete(); exp_pay.push_back(8'h05); exp_pay.push_back(8'h06);
        check_frame("max2", base, 8'h03);

        conf_en = 1'b0;
        start = 1'b1;
        wait_state("tmo_conf", 8'h04, 50);
        n = 0;
        while (!err && n < 100) begin @(negedge clk); n++; end
        check("tmo_cycles", n, 20);
        check("tmo_state", state, 8'h01);
        check("tmo_fsconf", fs_conf, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("tmo_sticky", err, 1'b1);
        wait_state("tmo_idle", 8'h01, 100);
        conf_en = 1'b1;
        check("tmo_sticky2", err, 1'b1);

        q1.push_back(8'hC1); q1.push_back(8'hC2); q1.push_back(8'hC3);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!(state == 8'h40 && m_valid) && n < 200) begin @(negedge clk); n++; end
        check("rd_reach", {state, 7'd0, m_valid}, {8'h40, 7'd0, 1'b1});
        rst = 1'b0;
        #1;
        check("rd_state", state, 8'h01);
        check("rd_outs", {fs_check, fs_conf, fs_read, fifo_rxen, m_valid, m_last, err}, 32'd0);
        check("rd_mdata", m_data, 8'h00);
        check("rd_fcnt", frame_cnt, 8'h00);
        start = 1'b0;
        q1.delete(); q0.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        base = cap.size();
        l0 = n_last;
        start = 1'b1;
        wait_lasts("wrap256", l0 + 256, 20000);
        @(posedge clk); #1;
        check("wrap_fcnt", frame_cnt, 8'h00);
        wait_lasts("wrap257", l0 + 257, 200);
        start = 1'b0;
        check("wrap_hdr255", cap.size() > base + 766 ? cap[base + 766] : 8'h55, 8'hFF);
        check("wrap_hdr256", cap.size() > base + 769 ? cap[base + 769] : 8'h55, 8'h00);
        check("wrap_len", cap.size() >= base + 771, 1'b1);
        wait_state("end_idle", 8'h01, 100);

        check("rxen_only_drain", v_rxen, 0);
        check("fs_only_state", v_fs, 0);
        check("stable_all", v_stall, 0);
        check("rxen_occ_all", v_rxocc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
